// File: rtl/cpu_pipe_pkg.sv
// Shared MEM/WB pipeline types: stage payload width, SRAM data width and the
// per-entry record held by the WB stage queue.
package cpu_pipe_pkg;
  localparam int MEM_WB_W    = 166;
  localparam int SRAM_DATA_W = 32;

  typedef struct packed {
    logic                   vld;
    logic                   need;
    logic                   done;
    logic [MEM_WB_W-1:0]    data;
    logic [SRAM_DATA_W-1:0] rdata;
  } wb_q_entry_t;
endpackage

// File: rtl/wb_stage_queue_if.sv
// Handshake bundle for the MEM->WB queue: upstream push, SRAM response,
// downstream pop and occupancy status. slave = queue side, master = driver side.
interface wb_stage_queue_if #(
  parameter int DATA_W  = 166,
  parameter int RDATA_W = 32,
  parameter int CNT_W   = 2
);
  logic               flush;
  logic               in_valid;
  logic               in_allowin;
  logic [DATA_W-1:0]  in_data;
  logic               in_req_is_use;
  logic               data_sram_data_ok;
  logic [RDATA_W-1:0] data_sram_rdata;
  logic               out_valid;
  logic               out_allowin;
  logic [DATA_W-1:0]  out_data;
  logic [RDATA_W-1:0] out_rdata;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   discard_cnt;

  modport slave (
    input  flush, in_valid, in_data, in_req_is_use, data_sram_data_ok,
           data_sram_rdata, out_allowin,
    output in_allowin, out_valid, out_data, out_rdata, count, discard_cnt
  );
  modport master (
    output flush, in_valid, in_data, in_req_is_use, data_sram_data_ok,
           data_sram_rdata, out_allowin,
    input  in_allowin, out_valid, out_data, out_rdata, count, discard_cnt
  );
endinterface

// File: rtl/wb_stage_queue_popcnt.sv
// Population count of outstanding-response flags, used to size the discard
// backlog when a flush drops entries that still owe an SRAM response.
module wb_q_popcnt #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
)(
  input  logic [DEPTH-1:0] bits,
  output logic [CNT_W-1:0] cnt
);
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + CNT_W'(bits[i]);
  end
endmodule

// File: rtl/wb_stage_queue.sv
// DEPTH-entry in-order MEM->WB queue with in-order SRAM response capture and
// flush-safe discard. Define WB_STAGE_QUEUE_PERF_EN for stall/backpressure counters.
module wb_stage_queue import cpu_pipe_pkg::*; #(
  parameter int DATA_W  = MEM_WB_W,
  parameter int RDATA_W = SRAM_DATA_W,
  parameter int DEPTH   = 2,
  parameter int CNT_W   = $clog2(DEPTH + 1)
)(
  input  logic        clk,
  input  logic        reset,
`ifdef WB_STAGE_QUEUE_PERF_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] bp_cnt,
`endif
  wb_stage_queue_if.slave q
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef logic [PTR_W-1:0] ptr_t;

  wb_q_entry_t [DEPTH-1:0] ent_q, ent_d;
  ptr_t                    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]        count_q, count_d, disc_q, disc_d, pend_cnt;
  logic [DEPTH-1:0]        pend_post;
  wb_q_entry_t             head;
  ptr_t                    rptr;
  logic                    tgt_vld, disc_hit, route, head_rdy, out_valid, pop, push;
  logic [DATA_W-1:0]       out_data;
  logic [RDATA_W-1:0]      out_rdata;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (int'(p) == DEPTH - 1) ? '0 : p + ptr_t'(1);
  endfunction

  // Responses return in request order, so the target is the oldest entry
  // (from head) still owed one.
  always_comb begin
    ptr_t idx;
    idx     = '0;
    rptr    = head_q;
    tgt_vld = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = ptr_t'((int'(head_q) + k) % DEPTH);
      if (!tgt_vld && ent_q[idx].vld && ent_q[idx].need && !ent_q[idx].done) begin
        rptr    = idx;
        tgt_vld = 1'b1;
      end
    end
  end

  assign head     = ent_q[head_q];
  assign disc_hit = q.data_sram_data_ok && (disc_q != '0);
  assign route    = q.data_sram_data_ok && (disc_q == '0) && tgt_vld;
  assign head_rdy = head.vld && (!head.need || head.done || (route && rptr == head_q));
  assign out_valid = head_rdy && !q.flush;
  assign pop      = out_valid && q.out_allowin;
  assign q.in_allowin = (int'(count_q) + int'(disc_q) < DEPTH) || pop;
  assign push     = q.in_valid && q.in_allowin && !q.flush;

  assign out_data  = head.vld ? head.data : '0;
  assign out_rdata = !head.vld ? '0 :
                     (head.need && !head.done) ? q.data_sram_rdata : head.rdata;
  assign q.out_valid   = out_valid;
  assign q.out_data    = out_data;
  assign q.out_rdata   = out_rdata;
  assign q.count       = count_q;
  assign q.discard_cnt = disc_q;

  // A response landing on an entry in the flush cycle completes it, so it is
  // excluded from the discard backlog.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      pend_post[i] = ent_q[i].vld && ent_q[i].need && !ent_q[i].done &&
                     !(route && rptr == ptr_t'(i));
  end

  wb_q_popcnt #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_popcnt (
    .bits (pend_post),
    .cnt  (pend_cnt)
  );

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    disc_d  = disc_q - CNT_W'(disc_hit);
    if (q.flush) begin
      ent_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      disc_d  = disc_q - CNT_W'(disc_hit) + pend_cnt;
    end else begin
      if (route) begin
        ent_d[rptr].done  = 1'b1;
        ent_d[rptr].rdata = q.data_sram_rdata;
      end
      if (pop) begin
        ent_d[head_q].vld = 1'b0;
        head_d = ptr_inc(head_q);
      end
      // Pop-before-push ordering lets a full queue reuse the head slot.
      if (push) begin
        ent_d[tail_q].vld   = 1'b1;
        ent_d[tail_q].need  = q.in_req_is_use;
        ent_d[tail_q].done  = 1'b0;
        ent_d[tail_q].data  = q.in_data;
        ent_d[tail_q].rdata = '0;
        tail_d = ptr_inc(tail_q);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      disc_q  <= '0;
    end else begin
      ent_q   <= ent_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      disc_q  <= disc_d;
    end
  end

`ifdef WB_STAGE_QUEUE_PERF_EN
  logic [31:0] stall_q, stall_d, bp_q, bp_d;

  always_comb begin
    stall_d = stall_q;
    bp_d    = bp_q;
    if (head.vld && !head_rdy && stall_q != '1) stall_d = stall_q + 32'd1;
    if (out_valid && !q.out_allowin && bp_q != '1) bp_d = bp_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else begin
      stall_q <= stall_d;
      bp_q    <= bp_d;
    end
  end

  assign stall_cnt = stall_q;
  assign bp_cnt    = bp_q;
`endif

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
    !(q.data_sram_data_ok && disc_q == '0 && !tgt_vld));
  a_occupancy: assert property (@(posedge clk) disable iff (reset)
    int'(count_q) + int'(disc_q) <= DEPTH);
endmodule

// File: tb/tb_wb_stage_queue.sv
// Directed bench for wb_stage_queue (DEPTH=2): queue-based reference model
// checked every cycle, plus literal expectations at key points of each scenario.
module tb_wb_stage_queue;
  localparam int DEPTH = 2;

  logic clk, reset;
  wb_stage_queue_if #(.DATA_W(166), .RDATA_W(32), .CNT_W(2)) bus();
`ifdef WB_STAGE_QUEUE_PERF_EN
  logic [31:0] stall_cnt, bp_cnt;
`endif

  wb_stage_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef WB_STAGE_QUEUE_PERF_EN
    .stall_cnt (stall_cnt),
    .bp_cnt    (bp_cnt),
`endif
    .q         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [165:0] pl(input logic [31:0] v);
    return {v, v, v, v, v, v[5:0]};
  endfunction

  // Reference model: in-order list of live entries plus a discard backlog.
  typedef struct {
    logic [165:0] data;
    bit           need;
    bit           done;
    logic [31:0]  rdata;
  } ment_t;

  ment_t        mq[$];
  ment_t        mt;
  int           mdisc, m_p, m_n;
  bit           m_route, m_rdy, m_ev, m_ea;
  logic [165:0] e_data;
  logic [31:0]  e_rd;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      mdisc = 0;
      check("m_rst_valid", bus.out_valid, 0);
      check("m_rst_count", bus.count, 0);
      check("m_rst_disc", bus.discard_cnt, 0);
    end else begin
      m_p = -1;
      foreach (mq[i]) if (m_p < 0 && mq[i].need && !mq[i].done) m_p = i;
      m_route = bus.data_sram_data_ok && mdisc == 0 && m_p >= 0;
      m_rdy   = mq.size() > 0 && (!mq[0].need || mq[0].done || (m_route && m_p == 0));
      m_ev    = m_rdy && !bus.flush;
      m_ea    = (mq.size() + mdisc < DEPTH) || (m_ev && bus.out_allowin);
      e_data  = (mq.size() > 0) ? mq[0].data : '0;
      e_rd    = (mq.size() == 0) ? 32'h0 : (m_route && m_p == 0) ? bus.data_sram_rdata : mq[0].rdata;
      check("m_out_valid", bus.out_valid, m_ev);
      check("m_in_allowin", bus.in_allowin, m_ea);
      check("m_count", bus.count, mq.size());
      check("m_discard", bus.discard_cnt, mdisc);
      check("m_out_data", bus.out_data, e_data);
      if (m_ev || mq.size() == 0) check("m_out_rdata", bus.out_rdata, e_rd);
      // advance the model with this cycle's inputs
      if (bus.data_sram_data_ok) begin
        if (mdisc > 0) mdisc--;
        else if (m_p >= 0) begin
          mt = mq[m_p]; mt.done = 1; mt.rdata = bus.data_sram_rdata; mq[m_p] = mt;
        end
      end
      if (bus.flush) begin
        m_n = 0;
        foreach (mq[i]) if (mq[i].need && !mq[i].done) m_n++;
        mdisc += m_n;
        mq.delete();
      end else begin
        if (m_ev && bus.out_allowin) void'(mq.pop_front());
        if (bus.in_valid && m_ea) begin
          mt.data = bus.in_data; mt.need = bus.in_req_is_use; mt.done = 0; mt.rdata = '0;
          mq.push_back(mt);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] v, input bit req);
    bus.in_valid = 1'b1; bus.in_data = pl(v); bus.in_req_is_use = req;
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 0; bus.in_valid = 0; bus.in_data = '0; bus.in_req_is_use = 0;
    bus.data_sram_data_ok = 0; bus.data_sram_rdata = '0; bus.out_allowin = 0;
    repeat (2) @(posedge clk); #1;
    check("reset_valid", bus.out_valid, 0);
    check("reset_count", bus.count, 0);
    check("reset_disc", bus.discard_cnt, 0);
    check("reset_data", bus.out_data, 0);
    check("reset_rdata", bus.out_rdata, 0);
    reset = 1'b0;
    bus.out_allowin = 1'b1;

    // no-request entry: visible one cycle after push
    push(32'hA0, 0);
    cyc(); bus.in_valid = 0; #1;
    check("t1_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, pl(32'hA0));
    check("t1_rdata", bus.out_rdata, 0);

    // request entry completes in the data_ok cycle
    cyc(); push(32'hB1, 1);
    cyc(); bus.in_valid = 0; #1;
    check("t2_wait_valid", bus.out_valid, 0);
    check("t2_wait_count", bus.count, 1);
    cyc(); cyc();
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'hDEADBEEF; #1;
    check("t2_valid", bus.out_valid, 1);
    check("t2_rdata", bus.out_rdata, 32'hDEADBEEF);
    check("t2_data", bus.out_data, pl(32'hB1));
    cyc(); bus.data_sram_data_ok = 0; #1;
    check("t2_count", bus.count, 0);

    // full queue, then simultaneous push and pop
    bus.out_allowin = 0;
    push(32'hC2, 0); cyc();
    push(32'hD3, 0); cyc();
    bus.in_valid = 0; #1;
    check("t3_full_count", bus.count, 2);
    check("t3_full_allowin", bus.in_allowin, 0);
    check("t3_head", bus.out_data, pl(32'hC2));
    bus.out_allowin = 1; push(32'hE4, 0); #1;
    check("t3_allowin", bus.in_allowin, 1);
    cyc(); bus.in_valid = 0; #1;
    check("t3_count_kept", bus.count, 2);
    check("t3_next_head", bus.out_data, pl(32'hD3));
    cyc(); cyc();
    check("t3_drained", bus.count, 0);

    // flush with two pending requests, then discard two responses
    push(32'hF5, 1); cyc();
    push(32'h16, 1); cyc();
    bus.in_valid = 0; #1;
    check("t4_count", bus.count, 2);
    bus.flush = 1;
    cyc(); bus.flush = 0; #1;
    check("t4_flush_count", bus.count, 0);
    check("t4_flush_disc", bus.discard_cnt, 2);
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h1111;
    cyc(); #1;
    check("t4_disc1", bus.discard_cnt, 1);
    check("t4_drop_valid", bus.out_valid, 0);
    bus.data_sram_rdata = 32'h2222;
    cyc(); bus.data_sram_data_ok = 0; #1;
    check("t4_disc0", bus.discard_cnt, 0);
    push(32'h27, 1);
    cyc(); bus.in_valid = 0;
    bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h3333; #1;
    check("t4_valid", bus.out_valid, 1);
    check("t4_rdata", bus.out_rdata, 32'h3333);
    check("t4_data", bus.out_data, pl(32'h27));
    cyc(); bus.data_sram_data_ok = 0; #1;
    check("t4_count_end", bus.count, 0);

    // flush together with a routed response, one other entry pending
    push(32'h38, 1); cyc();
    push(32'h49, 1); cyc();
    bus.in_valid = 0;
    bus.flush = 1; bus.data_sram_data_ok = 1; bus.data_sram_rdata = 32'h4444; #1;
    check("t5_flush_valid", bus.out_valid, 0);
    cyc(); bus.flush = 0; bus.data_sram_data_ok = 0; #1;
    check("t5_disc", bus.discard_cnt, 1);
    check("t5_count", bus.count, 0);
    bus.data_sram_data_ok = 1;
    cyc(); bus.data_sram_data_ok = 0; #1;
    check("t5_disc_end", bus.discard_cnt, 0);

    // asynchronous reset with an entry held and a response owed
    bus.out_allowin = 0;
    push(32'h5A, 1); cyc();
    push(32'h6B, 1); cyc();
    bus.in_valid = 0; bus.flush = 1;
    cyc(); bus.flush = 0; bus.data_sram_data_ok = 1;
    cyc(); bus.data_sram_data_ok = 0; push(32'h7C, 0);
    cyc(); bus.in_valid = 0; #1;
    check("t6_count", bus.count, 1);
    check("t6_disc", bus.discard_cnt, 1);
    check("t6_valid", bus.out_valid, 1);
    reset = 1; #1;
    check("t6_rst_valid", bus.out_valid, 0);
    check("t6_rst_count", bus.count, 0);
    check("t6_rst_disc", bus.discard_cnt, 0);
    check("t6_rst_data", bus.out_data, 0);
    check("t6_rst_rdata", bus.out_rdata, 0);
    cyc(); reset = 0; bus.out_allowin = 1; push(32'h8D, 0);
    cyc(); bus.in_valid = 0; #1;
    check("t6_post_valid", bus.out_valid, 1);
    check("t6_post_data", bus.out_data, pl(32'h8D));
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
